// File: rtl/product_bcd_converter_if.sv
// Start/product request and BCD result bundle for product_bcd_converter.
// master drives the request, slave (the converter) returns the result.
interface product_bcd_converter_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  Start;
  logic [WIDTH-1:0]      Prod;
  logic                  Busy;
  logic                  Done;
  logic                  Neg;
  logic [4*DIGITS-1:0]   BCD;
  logic [DIGITS-1:0]     Blank;

  modport master (
    output Start, Prod,
    input  Busy, Done, Neg, BCD, Blank
  );

  modport slave (
    input  Start, Prod,
    output Busy, Done, Neg, BCD, Blank
  );
endinterface

// File: rtl/product_bcd_converter.sv
// Serial double-dabble converter: signed product to sign + BCD digits.
// BCD_BLANK_LEADING_ZERO_EN enables the leading-zero blank mask.
module product_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic Clk,
  input  logic Reset,
  product_bcd_converter_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic             sign;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    work;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    count;
  logic             busy_q;
  logic             done_q;
  logic             neg_q;
  logic [BW-1:0]    bcd_q;

  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i+:4] >= 4'd5)
        adj[4*i+:4] = work[4*i+:4] + 4'd3;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      sign   <= 1'b0;
      mag    <= '0;
      work   <= '0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      neg_q  <= 1'b0;
      bcd_q  <= '0;
    end else begin
      busy_q <= (state == LOAD) || (state == SHIFT);
      done_q <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (bus.Start)
            state <= LOAD;
        end
        LOAD: begin
          sign  <= bus.Prod[WIDTH-1];
          mag   <= bus.Prod[WIDTH-1]
                   ? (~bus.Prod + WIDTH'(1))
                   : bus.Prod;
          work  <= '0;
          count <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          work  <= {adj[BW-2:0], mag[WIDTH-1]};
          mag   <= {mag[WIDTH-2:0], 1'b0};
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1))
            state <= DONE;
        end
        DONE: begin
          bcd_q <= work;
          neg_q <= sign;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Neg  = neg_q;
  assign bus.BCD  = bcd_q;

`ifdef BCD_BLANK_LEADING_ZERO_EN
  logic [DIGITS-1:0] blank_nxt;
  logic [DIGITS-1:0] blank_q;

  // a digit blanks only when it and every digit above it are zero
  always_comb begin
    logic zero;
    zero      = 1'b1;
    blank_nxt = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero         = zero & (work[4*i+:4] == 4'd0);
      blank_nxt[i] = zero;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      blank_q <= '0;
    else if (state == DONE)
      blank_q <= blank_nxt;
  end

  assign bus.Blank = blank_q;
`else
  assign bus.Blank = '0;
`endif
endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomised bench for product_bcd_converter against an arithmetic model.
// Directed conversions pin latency, digits, sign and blanking literals.
module tb_product_bcd_converter;
  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
`ifdef BCD_BLANK_LEADING_ZERO_EN
  localparam logic [4:0] BL_SMALL = 5'b11110;
`else
  localparam logic [4:0] BL_SMALL = 5'b00000;
`endif

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;
  bit   chk_en;

  product_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  product_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int magof(input logic [15:0] p);
    int v;
    v = int'($signed(p));
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [19:0] to_bcd(input logic [15:0] p);
    logic [19:0] r;
    int m;
    m = magof(p);
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] to_blank(input logic [15:0] p);
    logic [4:0] b;
    int lim;
    b   = '0;
    lim = 1;
`ifdef BCD_BLANK_LEADING_ZERO_EN
    for (int i = 1; i < DIGITS; i++) begin
      lim  = lim * 10;
      b[i] = (magof(p) < lim);
    end
`else
    lim = magof(p);
`endif
    return b;
  endfunction

  // model: m_t = edges since Start was accepted, -1 when idle
  int          m_t;
  logic [15:0] m_prod;
  logic [19:0] m_bcd;
  logic        m_neg;
  logic [4:0]  m_blank;

  always @(posedge Clk) begin
    if (Reset) begin
      m_t     <= -1;
      m_bcd   <= '0;
      m_neg   <= 1'b0;
      m_blank <= '0;
    end else if (m_t == -1 || m_t == 18) begin
      m_t <= bus.Start ? 0 : -1;
    end else begin
      m_t <= m_t + 1;
      if (m_t == 0)
        m_prod <= bus.Prod;
      if (m_t == 17) begin
        m_bcd   <= to_bcd(m_prod);
        m_neg   <= ($signed(m_prod) < 0);
        m_blank <= to_blank(m_prod);
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus.Busy), 32'(m_t >= 1 && m_t <= 17));
      chk("done", 32'(bus.Done), 32'(m_t == 18));
      if (m_t != 17) begin
        chk("bcd", 32'(bus.BCD), 32'(m_bcd));
        chk("neg", 32'(bus.Neg), 32'(m_neg));
        chk("blank", 32'(bus.Blank), 32'(m_blank));
      end
    end
  end

  task automatic conv(input logic [15:0] p,
                      input logic [19:0] eb,
                      input logic        en,
                      input logic [4:0]  ebl);
    int n;
    int bc;
    bit got;
    n   = 0;
    bc  = 0;
    got = 0;
    bus.Prod  = p;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    while (n < 40 && !got) begin
      @(posedge Clk);
      #1;
      n++;
      if (n == 1)
        bus.Prod = 16'($urandom);
      if (bus.Done)
        got = 1;
      else if (bus.Busy)
        bc++;
    end
    chk("latency", 32'(n), 32'd18);
    chk("busy_cycles", 32'(bc), 32'd17);
    chk("lit_bcd", 32'(bus.BCD), 32'(eb));
    chk("lit_neg", 32'(bus.Neg), 32'(en));
    chk("lit_blank", 32'(bus.Blank), 32'(ebl));
  endtask

  initial begin
    int dn;
    int first;
    int second;
    checks    = 0;
    errors    = 0;
    chk_en    = 0;
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Prod  = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_bcd", 32'(bus.BCD), 32'd0);
    chk("rst_neg", 32'(bus.Neg), 32'd0);
    chk("rst_blank", 32'(bus.Blank), 32'd0);
    chk_en = 1;
    Reset  = 1'b0;

    conv(16'h0000, 20'h00000, 1'b0, BL_SMALL);
    conv(16'h3F01, 20'h16129, 1'b0, 5'b00000);
    conv(16'hC080, 20'h16256, 1'b1, 5'b00000);
    conv(16'h8000, 20'h32768, 1'b1, 5'b00000);

    bus.Prod  = 16'h0007;
    bus.Start = 1'b1;
    dn     = 0;
    first  = 0;
    second = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clk);
      #1;
      if (bus.Done) begin
        dn++;
        if (first == 0)
          first = n;
        else
          second = n;
        chk("held_bcd", 32'(bus.BCD), 32'h00007);
        chk("held_blank", 32'(bus.Blank), 32'(BL_SMALL));
      end
    end
    bus.Start = 1'b0;
    chk("held_pulses", 32'(dn), 32'd2);
    chk("held_first", 32'(first), 32'd19);
    chk("held_space", 32'(second - first), 32'd19);
    repeat (25) @(posedge Clk);
    #1;

    bus.Prod  = 16'h3F01;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("mid_rst_busy", 32'(bus.Busy), 32'd0);
    chk("mid_rst_bcd", 32'(bus.BCD), 32'd0);
    chk("mid_rst_neg", 32'(bus.Neg), 32'd0);
    Reset = 1'b0;
    dn = 0;
    repeat (30) begin
      @(posedge Clk);
      #1;
      if (bus.Done)
        dn++;
    end
    chk("mid_rst_nodone", 32'(dn), 32'd0);

    conv(16'hFFFF, 20'h00001, 1'b1, BL_SMALL);
    bus.Prod = 16'h1234;
    repeat (25) @(posedge Clk);
    #1;
    chk("hold_bcd", 32'(bus.BCD), 32'h00001);
    chk("hold_neg", 32'(bus.Neg), 32'd1);

    repeat (400) begin
      @(posedge Clk);
      #1;
      bus.Prod  = 16'($urandom);
      bus.Start = ($urandom_range(3) == 0);
      Reset     = ($urandom_range(150) == 0);
    end
    Reset     = 1'b0;
    bus.Start = 1'b0;
    repeat (25) @(posedge Clk);
    #1;
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
